rv_decode_stage: RTL and testbench
==================================

Name: rv_decode_stage

Overview:
- Registered, parametrised RISC-V instruction-decode pipeline stage, placed between the fetch stage and the register-read/execute stage.
- Decodes RV32I/RV64I base encodings into operand indices, a sign-extended XLEN-wide immediate, a format code and an error flag.
- Decodes the B-type immediate exactly as the ISA defines it (12-bit offset, bit 0 = 0), reports source-register usage, and is `XLEN`-generic.
- Has a valid/ready handshake with a 2-entry skid buffer (registered `in_ready`) and a synchronous flush for branch redirects.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. Sets the `imm` and `pc` widths and enables the RV64 opcodes.
- PC_W, XLEN, width of the PC carried alongside the instruction.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  discard all buffered instructions (synchronous)
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  stage can accept; registered
- in_instr  input  32  raw instruction word
- in_pc  input  PC_W  PC of in_instr
- out_valid  output  1  decoded instruction available
- out_ready  input  1  downstream accepts
- out_pc  output  PC_W  PC of the decoded instruction
- out_opcode  output  5  instr[6:2]
- out_funct3  output  3  instr[14:12]
- out_funct7  output  7  instr[31:25]
- out_rd  output  5  instr[11:7]
- out_rd_valid  output  1  writes a register and rd != 0
- out_rs1  output  5  instr[19:15]
- out_rs1_valid  output  1  rs1 is read
- out_rs2  output  5  instr[24:20]
- out_rs2_valid  output  1  rs2 is read
- out_imm  output  XLEN  sign-extended immediate
- out_fmt  output  3  format: R=0, I=1, S=2, B=3, U=4, J=5, NONE=7
- out_error  output  1  illegal/unsupported encoding

Behaviour:
- Reset (async assert): out_valid=0, skid empty, in_ready=1 after release; all out_* data fields = 0.
- Decode is combinational on in_instr; the result is captured with the instruction at acceptance (in_valid && in_ready). Latency is 1 cycle from acceptance to out_valid.
- Opcode map (instr[6:2]), with fmt / rd_valid / rs1_valid / rs2_valid:
  - 00000 LOAD: I, 1, 1, 0
  - 00011 MISC-MEM: I, 0, 0, 0
  - 00100 OP-IMM: I, 1, 1, 0
  - 00101 AUIPC: U, 1, 0, 0
  - 00110 OP-IMM-32: I, 1, 1, 0 (XLEN=64 only)
  - 01000 STORE: S, 0, 1, 1
  - 01100 OP: R, 1, 1, 1
  - 01101 LUI: U, 1, 0, 0
  - 01110 OP-32: R, 1, 1, 1 (XLEN=64 only)
  - 11000 BRANCH: B, 0, 1, 1
  - 11001 JALR: I, 1, 1, 0
  - 11011 JAL: J, 1, 0, 0
  - 11100 SYSTEM: I, 1, rs1_valid=(funct3 in {001,010,011}), 0
- rd_valid is additionally forced to 0 when rd=0.
- Immediates, all sign-extended from instr[31] to XLEN:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R/NONE: 0
- out_error=1, fmt=NONE, all *_valid=0 when any of these holds:
  - instr[1:0] != 2'b11
  - opcode not in the map
  - OP-IMM-32/OP-32 with XLEN=32
- An errored instruction still flows through the handshake normally.
- Buffering:
  - Main output register plus one skid entry.
  - Output register loads from skid if skid is full, else from input, whenever it is empty or drained (out_ready).
  - An accepted input that cannot enter the output register goes to the skid.
  - in_ready(next) = skid empty after this edge. With out_ready=0, at most 2 instructions are held.
  - Order is strictly FIFO; no entry is dropped or duplicated.
- out_* fields hold their value while out_valid && !out_ready.
- flush: at the edge it is sampled high, out_valid=0, skid cleared, in_ready=1. An input presented in the same cycle is discarded. Flush has priority over accept and drain.
- Reset mid-transfer: all buffered entries are lost; no out_valid pulse after release until a new acceptance.

Test Plan:
- XLEN=32, in_instr=0xFFF10093 (addi x1,x2,-1), out_ready=1 -> next cycle out_valid=1, opcode=00100, rd=1, rd_valid=1, rs1=2, rs1_valid=1, rs2_valid=0, imm=0xFFFFFFFF, fmt=1, error=0.
- in_instr=0xFE000EE3 (beq x0,x0,-4) -> fmt=3, imm=0xFFFFFFFC, rd_valid=0, rs1_valid=1, rs2_valid=1; in_instr=0x00C0006F (jal x0,12) -> fmt=5, imm=12, rd_valid=0.
- Errors:
  - XLEN=32, 0x0000003B (addw) -> error=1, fmt=7.
  - XLEN=64, same word -> error=0, fmt=0, imm=0.
  - 0x00000001 -> error=1.
- Backpressure: out_ready=0, push A,B,C back-to-back -> A,B accepted; in_ready=0 before C's edge. Then out_ready=1 -> outputs A,B,C in order, in_ready returns to 1.
- Flush with 2 held entries plus in_valid=1 -> next cycle out_valid=0, in_ready=1; none of the three instructions ever appears.
- Assert rst while holding 2 entries -> out_valid=0, in_ready=1 after release, out_imm=0.

Source files
------------

// File: rtl/rv_decode_if.sv
// Handshake and data bundle between fetch, the decode stage and register-read.
// The stage sits on the slave side. The producer/consumer pair sits on the master side.
interface rv_decode_if #(
  parameter int XLEN = 32,
  parameter int PC_W = XLEN
);
  // Upstream (fetch) side
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;

  // Downstream (register-read / execute) side
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [4:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [4:0]      out_rd;
  logic            out_rd_valid;
  logic [4:0]      out_rs1;
  logic            out_rs1_valid;
  logic [4:0]      out_rs2;
  logic            out_rs2_valid;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_error;

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
           out_rd, out_rd_valid, out_rs1, out_rs1_valid, out_rs2, out_rs2_valid,
           out_imm, out_fmt, out_error
  );

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
           out_rd, out_rd_valid, out_rs1, out_rs1_valid, out_rs2, out_rs2_valid,
           out_imm, out_fmt, out_error
  );
endinterface

// File: rtl/rv_decode_stage.sv
// RV32I/RV64I decode pipeline stage.
// Decode is combinational on the incoming word and is captured at acceptance.
// Storage is one output register backed by one skid entry, so in_ready comes
// straight from a flop.
module rv_decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = XLEN
) (
  input  logic          clk,
  input  logic          rst,
  rv_decode_if.slave    bus
);

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  localparam logic [4:0] OP_LOAD     = 5'b00000;
  localparam logic [4:0] OP_MISC_MEM = 5'b00011;
  localparam logic [4:0] OP_OP_IMM   = 5'b00100;
  localparam logic [4:0] OP_AUIPC    = 5'b00101;
  localparam logic [4:0] OP_OP_IMM32 = 5'b00110;
  localparam logic [4:0] OP_STORE    = 5'b01000;
  localparam logic [4:0] OP_OP       = 5'b01100;
  localparam logic [4:0] OP_LUI      = 5'b01101;
  localparam logic [4:0] OP_OP32     = 5'b01110;
  localparam logic [4:0] OP_BRANCH   = 5'b11000;
  localparam logic [4:0] OP_JALR     = 5'b11001;
  localparam logic [4:0] OP_JAL      = 5'b11011;
  localparam logic [4:0] OP_SYSTEM   = 5'b11100;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic            rd_valid;
    logic [4:0]      rs1;
    logic            rs1_valid;
    logic [4:0]      rs2;
    logic            rs2_valid;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            error;
  } dec_t;

  dec_t        dec;
  dec_t        out_q;
  dec_t        skid_q;
  logic        out_valid_q;
  logic        skid_valid_q;
  logic        legal;
  logic [31:0] w;

  assign w = bus.in_instr;

  // Combinational decode of the presented instruction word
  always_comb begin
    // NOTE: every field gets a default before the case, so no path leaves a
    // variable unassigned and no latch is inferred.
    dec           = '0;
    legal         = 1'b1;
    dec.pc        = bus.in_pc;
    dec.opcode    = w[6:2];
    dec.funct3    = w[14:12];
    dec.funct7    = w[31:25];
    dec.rd        = w[11:7];
    dec.rs1       = w[19:15];
    dec.rs2       = w[24:20];
    dec.fmt       = FMT_NONE;

    case (w[6:2])
      OP_LOAD, OP_OP_IMM, OP_JALR: begin
        dec.fmt = FMT_I; dec.rd_valid = 1'b1; dec.rs1_valid = 1'b1;
      end
      OP_MISC_MEM: dec.fmt = FMT_I;
      OP_AUIPC, OP_LUI: begin
        dec.fmt = FMT_U; dec.rd_valid = 1'b1;
      end
      OP_OP_IMM32: begin
        if (XLEN == 64) begin
          dec.fmt = FMT_I; dec.rd_valid = 1'b1; dec.rs1_valid = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
      OP_STORE: begin
        dec.fmt = FMT_S; dec.rs1_valid = 1'b1; dec.rs2_valid = 1'b1;
      end
      OP_OP: begin
        dec.fmt = FMT_R; dec.rd_valid = 1'b1;
        dec.rs1_valid = 1'b1; dec.rs2_valid = 1'b1;
      end
      OP_OP32: begin
        if (XLEN == 64) begin
          dec.fmt = FMT_R; dec.rd_valid = 1'b1;
          dec.rs1_valid = 1'b1; dec.rs2_valid = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
      OP_BRANCH: begin
        dec.fmt = FMT_B; dec.rs1_valid = 1'b1; dec.rs2_valid = 1'b1;
      end
      OP_JAL: begin
        dec.fmt = FMT_J; dec.rd_valid = 1'b1;
      end
      OP_SYSTEM: begin
        dec.fmt       = FMT_I;
        dec.rd_valid  = 1'b1;
        dec.rs1_valid = (w[14:12] == 3'b001) || (w[14:12] == 3'b010) ||
                        (w[14:12] == 3'b011);
      end
      default: legal = 1'b0;
    endcase

    // Compressed / non-32-bit encodings are not supported here
    if (w[1:0] != 2'b11) legal = 1'b0;

    if (!legal) begin
      dec.fmt       = FMT_NONE;
      dec.rd_valid  = 1'b0;
      dec.rs1_valid = 1'b0;
      dec.rs2_valid = 1'b0;
    end
    dec.error = !legal;

    // x0 is never a real write target
    if (w[11:7] == 5'd0) dec.rd_valid = 1'b0;

    case (dec.fmt)
      FMT_I:   dec.imm = {{(XLEN-12){w[31]}}, w[31:20]};
      FMT_S:   dec.imm = {{(XLEN-12){w[31]}}, w[31:25], w[11:7]};
      FMT_B:   dec.imm = {{(XLEN-13){w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      FMT_U:   dec.imm = {{(XLEN-32){w[31]}}, w[31:12], 12'b0};
      FMT_J:   dec.imm = {{(XLEN-21){w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: dec.imm = '0;
    endcase
  end

  logic accept;
  logic out_load;

  assign accept   = bus.in_valid && bus.in_ready;
  assign out_load = !out_valid_q || bus.out_ready;

  // Output register plus skid entry; flush beats both accept and drain
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the decoded payload is reset as well as the valid bits, because
    // the outputs must read zero after reset and not only be marked invalid.
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_load) begin
      // in_ready is low whenever the skid is full, so accept and a full skid
      // never coincide here.
      // NOTE: state updates use non-blocking assignments so every flop sees
      // the pre-edge values of the others regardless of statement order.
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_q        <= dec;
        out_valid_q  <= 1'b1;
      end else begin
        out_valid_q  <= 1'b0;
      end
    end else if (accept) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
    end
  end

  assign bus.in_ready      = !skid_valid_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_pc        = out_q.pc;
  assign bus.out_opcode    = out_q.opcode;
  assign bus.out_funct3    = out_q.funct3;
  assign bus.out_funct7    = out_q.funct7;
  assign bus.out_rd        = out_q.rd;
  assign bus.out_rd_valid  = out_q.rd_valid;
  assign bus.out_rs1       = out_q.rs1;
  assign bus.out_rs1_valid = out_q.rs1_valid;
  assign bus.out_rs2       = out_q.rs2;
  assign bus.out_rs2_valid = out_q.rs2_valid;
  assign bus.out_imm       = out_q.imm;
  assign bus.out_fmt       = out_q.fmt;
  assign bus.out_error     = out_q.error;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Self-checking bench for rv_decode_stage: directed decode cases, backpressure,
// flush, reset, and a randomised stream checked through an expected-value queue.
module tb_rv_decode_stage;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rv_decode_if #(.XLEN(32)) b32();
  rv_decode_if #(.XLEN(64)) b64();

  rv_decode_stage #(.XLEN(32)) u_dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
  rv_decode_stage #(.XLEN(64)) u_dut64 (.clk(clk), .rst(rst), .bus(b64.slave));

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic        rdv;
    logic [4:0]  rs1;
    logic        rs1v;
    logic [4:0]  rs2;
    logic        rs2v;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference decode, written from the ISA tables
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc, input bit rv64);
    exp_t e;
    bit ok, r, s1, s2;
    int f;
    e = '0;
    e.pc = pc; e.opcode = w[6:2]; e.funct3 = w[14:12]; e.funct7 = w[31:25];
    e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
    ok = (w[1:0] == 2'b11); f = 7; r = 0; s1 = 0; s2 = 0;
    case (w[6:2])
      5'b00000, 5'b00100, 5'b11001: begin f = 1; r = 1; s1 = 1; end
      5'b00011: f = 1;
      5'b00110: if (rv64) begin f = 1; r = 1; s1 = 1; end else ok = 0;
      5'b00101, 5'b01101: begin f = 4; r = 1; end
      5'b01000: begin f = 2; s1 = 1; s2 = 1; end
      5'b01100: begin f = 0; r = 1; s1 = 1; s2 = 1; end
      5'b01110: if (rv64) begin f = 0; r = 1; s1 = 1; s2 = 1; end else ok = 0;
      5'b11000: begin f = 3; s1 = 1; s2 = 1; end
      5'b11011: begin f = 5; r = 1; end
      5'b11100: begin f = 1; r = 1; s1 = (w[14:12] inside {3'd1, 3'd2, 3'd3}); end
      default: ok = 0;
    endcase
    if (!ok) begin f = 7; r = 0; s1 = 0; s2 = 0; end
    case (f)
      1: e.imm = {{52{w[31]}}, w[31:20]};
      2: e.imm = {{52{w[31]}}, w[31:25], w[11:7]};
      3: e.imm = {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      4: e.imm = {{32{w[31]}}, w[31:12], 12'h000};
      5: e.imm = {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: e.imm = 64'd0;
    endcase
    if (!rv64) e.imm[63:32] = 32'd0;
    e.fmt  = 3'(f);
    e.rdv  = r && (w[11:7] != 5'd0);
    e.rs1v = s1;
    e.rs2v = s2;
    e.err  = !ok;
    return e;
  endfunction

  function automatic exp_t obs32();
    exp_t o;
    o.pc = b32.out_pc; o.opcode = b32.out_opcode; o.funct3 = b32.out_funct3;
    o.funct7 = b32.out_funct7; o.rd = b32.out_rd; o.rdv = b32.out_rd_valid;
    o.rs1 = b32.out_rs1; o.rs1v = b32.out_rs1_valid; o.rs2 = b32.out_rs2;
    o.rs2v = b32.out_rs2_valid; o.imm = {32'd0, b32.out_imm};
    o.fmt = b32.out_fmt; o.err = b32.out_error;
    return o;
  endfunction

  // One clock of the 32-bit stage: scoreboard push on accept, pop on drain
  task automatic cycle();
    bit fi, fo;
    exp_t e;
    fi = b32.in_valid && b32.in_ready;
    fo = b32.out_valid && b32.out_ready;
    if (b32.flush) begin
      sbq.delete();
    end else begin
      if (fo) begin
        if (sbq.size() == 0) check("spurious_out", 1'b1, 1'b0);
        else begin
          e = sbq.pop_front();
          check("sb_entry", obs32(), e);
        end
      end
      if (fi) sbq.push_back(model(b32.in_instr, b32.in_pc, 1'b0));
    end
    @(posedge clk); #1;
  endtask

  // Present one instruction for one cycle on the 32-bit stage
  task automatic send1(input logic [31:0] instr, input logic [31:0] pc);
    b32.in_valid = 1'b1; b32.in_instr = instr; b32.in_pc = pc;
    cycle();
    b32.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 0;
    b32.out_ready = 1'b1;
    while ((sbq.size() != 0 || b32.out_valid) && budget < 50) begin
      cycle();
      budget++;
    end
    check(tag, 32'(budget < 50), 32'd1);
  endtask

  logic [4:0] ops[14] = '{5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
                          5'b01000, 5'b01100, 5'b01101, 5'b01110, 5'b11000,
                          5'b11001, 5'b11011, 5'b11100, 5'b01010};

  initial begin
    logic [31:0] w;
    bit acc;
    rst = 1'b1;
    b32.flush = 0; b32.in_valid = 0; b32.in_instr = '0; b32.in_pc = '0; b32.out_ready = 1;
    b64.flush = 0; b64.in_valid = 0; b64.in_instr = '0; b64.in_pc = '0; b64.out_ready = 1;
    #12;
    check("rst_out_valid", b32.out_valid, 1'b0);
    check("rst_imm", b32.out_imm, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", b32.in_ready, 1'b1);

    // addi x1,x2,-1 : one-cycle latency and field values
    send1(32'hFFF10093, 32'h100);
    check("addi_valid", b32.out_valid, 1'b1);
    check("addi_opcode", b32.out_opcode, 5'b00100);
    check("addi_rd", {b32.out_rd, b32.out_rd_valid}, {5'd1, 1'b1});
    check("addi_rs", {b32.out_rs1, b32.out_rs1_valid, b32.out_rs2_valid}, {5'd2, 1'b1, 1'b0});
    check("addi_imm", b32.out_imm, 32'hFFFFFFFF);
    check("addi_fmt_err", {b32.out_fmt, b32.out_error}, {3'd1, 1'b0});

    send1(32'hFE000EE3, 32'h104);  // beq x0,x0,-4
    check("beq_fmt", b32.out_fmt, 3'd3);
    check("beq_imm", b32.out_imm, 32'hFFFFFFFC);
    check("beq_valids", {b32.out_rd_valid, b32.out_rs1_valid, b32.out_rs2_valid}, 3'b011);

    send1(32'h00C0006F, 32'h108);  // jal x0,12
    check("jal_fmt_imm", {b32.out_fmt, b32.out_imm}, {3'd5, 32'd12});
    check("jal_rd_valid", b32.out_rd_valid, 1'b0);

    send1(32'h0000003B, 32'h10C);  // addw on RV32 is illegal
    check("addw32_err_fmt", {b32.out_error, b32.out_fmt}, {1'b1, 3'd7});

    send1(32'h00000001, 32'h110);
    check("low_bits_err", b32.out_error, 1'b1);
    cycle();

    // 64-bit stage: addw legal, addi sign-extends to 64 bits
    b64.in_valid = 1; b64.in_instr = 32'h0000003B; b64.in_pc = 64'h200;
    cycle();
    b64.in_instr = 32'hFFF10093;
    check("addw64_valid", b64.out_valid, 1'b1);
    check("addw64_err_fmt_imm", {b64.out_error, b64.out_fmt, b64.out_imm}, {1'b0, 3'd0, 64'd0});
    cycle();
    b64.in_valid = 0;
    check("addi64_imm", b64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);

    // Backpressure: A,B held, C stalled until drain begins
    b32.out_ready = 0;
    b32.in_valid = 1; b32.in_instr = 32'h00100093; b32.in_pc = 32'hA0; cycle();
    b32.in_instr = 32'h00200113; b32.in_pc = 32'hB0; cycle();
    check("bp_in_ready_low", b32.in_ready, 1'b0);
    b32.in_instr = 32'h00300193; b32.in_pc = 32'hC0; cycle();
    check("bp_hold_pc", b32.out_pc, 32'hA0);
    check("bp_hold_imm", b32.out_imm, 32'd1);
    b32.out_ready = 1;
    acc = 0;
    for (int i = 0; i < 10 && !acc; i++) begin
      acc = b32.in_ready;
      cycle();
    end
    b32.in_valid = 0;
    check("bp_c_accepted", acc, 1'b1);
    drain("bp_drain_budget");
    check("bp_in_ready_back", b32.in_ready, 1'b1);

    // Flush with two held entries and a third presented
    b32.out_ready = 0;
    send1(32'h00500293, 32'hD0);
    send1(32'h00600313, 32'hE0);
    b32.flush = 1; b32.in_valid = 1; b32.in_instr = 32'h00700393; b32.in_pc = 32'hF0;
    cycle();
    b32.flush = 0; b32.in_valid = 0;
    check("flush_out_valid", b32.out_valid, 1'b0);
    check("flush_in_ready", b32.in_ready, 1'b1);
    b32.out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("flush_quiet", b32.out_valid, 1'b0);
    end

    // Random stream with random backpressure
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      w[6:0] = {ops[$urandom_range(0, 13)], 2'b11};
      if ($urandom_range(0, 9) == 0) w[1:0] = 2'($urandom);
      b32.in_valid  = ($urandom_range(0, 3) != 0);
      b32.in_instr  = w;
      b32.in_pc     = $urandom;
      b32.out_ready = ($urandom_range(0, 9) < 6);
      cycle();
    end
    b32.in_valid = 0;
    drain("rand_drain_budget");

    // Reset while two entries are held
    b32.out_ready = 0;
    send1(32'h00800413, 32'h300);
    send1(32'h00900493, 32'h304);
    #2 rst = 1'b1;
    #1;
    check("midrst_async", b32.out_valid, 1'b0);
    sbq.delete();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_in_ready", b32.in_ready, 1'b1);
    check("midrst_imm", b32.out_imm, 32'd0);
    b32.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("midrst_quiet", b32.out_valid, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
